// File: rtl/fpu_mult_norm_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fpu_mult_norm_pkg : shared constants and S1 beat type for the FP multiplier
//                     normalize/round stage.                  Revision: 1.0
// ---------------------------------------------------------------------------
package fpu_mult_norm_pkg;

  localparam int C_EXP     = 8;
  localparam int C_MANT    = 23;
  localparam int C_BIAS    = 127;
  localparam int C_OP      = 32;
  localparam int C_PROD_W  = 2 * (C_MANT + 1);
  localparam int C_EXPIN_W = 10;
  localparam int C_EINT_W  = 11;
  localparam int C_EXP_MAX = 2 * C_BIAS + 1;

  localparam logic [1:0] C_RM_NEAREST  = 2'd0;
  localparam logic [1:0] C_RM_TRUNC    = 2'd1;
  localparam logic [1:0] C_RM_PLUSINF  = 2'd2;
  localparam logic [1:0] C_RM_MINUSINF = 2'd3;

  localparam logic [31:0] F_QNAN     = 32'h7FC00000;
  localparam logic [30:0] F_INF_MAG  = 31'h7F800000;
  localparam logic [30:0] F_MAXF_MAG = 31'h7F7FFFFF;

  typedef struct packed {
    logic [1:0]           rm;
    logic                 sign;
    logic [C_EXPIN_W-1:0] exp;
    logic [C_PROD_W-1:0]  prod;
    logic                 zero;
    logic                 inf;
    logic                 nan;
  } s1_beat_t;

endpackage
`default_nettype wire

// File: rtl/fpu_round.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fpu_round : combinational mantissa rounding increment with carry-out.
//                                                             Revision: 1.0
// ---------------------------------------------------------------------------
module fpu_round
  import fpu_mult_norm_pkg::*;
(
  input  logic [C_MANT:0] m,
  input  logic            g,
  input  logic            s,
  input  logic            sign,
  input  logic [1:0]      rm,
  output logic [C_MANT:0] m_rnd,
  output logic            carry
);

  logic inc;

  always_comb begin
    inc = 1'b0;
    case (rm)
      C_RM_NEAREST:  inc = g & (s | m[0]);
      C_RM_TRUNC:    inc = 1'b0;
      C_RM_PLUSINF:  inc = ~sign & (g | s);
      C_RM_MINUSINF: inc = sign & (g | s);
      default:       inc = 1'b0;
    endcase
  end

  // A carry out means the mantissa wrapped to zero; the caller bumps the exponent.
  assign {carry, m_rnd} = {1'b0, m} + {{(C_MANT + 1){1'b0}}, inc};

endmodule
`default_nettype wire

// File: rtl/fpu_mult_norm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fpu_mult_norm : normalize/round/pack stage of the FP multiplier, two-deep
//                 valid/ready pipeline. Flags_DO with FPU_MULT_NORM_FLAGS_EN.
//                                                             Revision: 1.0
// ---------------------------------------------------------------------------
module fpu_mult_norm
  import fpu_mult_norm_pkg::*;
(
  input  logic                 Clk_CI,
  input  logic                 Rst_RI,
  input  logic                 In_valid_SI,
  output logic                 In_ready_SO,
  input  logic [1:0]           RM_DI,
  input  logic                 Sign_prenorm_DI,
  input  logic [C_EXPIN_W-1:0] Exp_prenorm_DI,
  input  logic [C_PROD_W-1:0]  Mant_prod_DI,
  input  logic                 Zero_SI,
  input  logic                 Inf_SI,
  input  logic                 NaN_SI,
  output logic                 Out_valid_SO,
  input  logic                 Out_ready_SI,
  output logic [C_OP-1:0]      Result_DO
`ifdef FPU_MULT_NORM_FLAGS_EN
  ,
  output logic [2:0]           Flags_DO
`endif
);

  logic           s1_v_q, s1_v_d;
  s1_beat_t       s1_q, s1_d;
  logic           s2_v_q, s2_v_d;
  logic [C_OP-1:0] res_q, res_d;

  logic s2_ready, accept;

  assign s2_ready    = ~s2_v_q | Out_ready_SI;
  assign In_ready_SO = ~Rst_RI & (~s1_v_q | s2_ready);
  assign accept      = In_valid_SI & In_ready_SO;

  // ---- normalize ----
  logic                hi, g, s;
  logic [C_MANT:0]     m_n, m_rnd;
  logic                carry;
  logic [C_EINT_W-1:0] e_norm, e_fin;
  logic                ovf, unf, to_inf;
  logic [C_OP-1:0]     res_next;
  logic                unused_hidden;

  assign hi  = s1_q.prod[C_PROD_W-1];
  assign m_n = hi ? s1_q.prod[C_PROD_W-1 -: C_MANT+1] : s1_q.prod[C_PROD_W-2 -: C_MANT+1];
  assign g   = hi ? s1_q.prod[C_MANT]  : s1_q.prod[C_MANT-1];
  assign s   = hi ? |s1_q.prod[C_MANT-1:0] : |s1_q.prod[C_MANT-2:0];

  // One guard bit of headroom so Exp+2 can never wrap.
  assign e_norm = {s1_q.exp[C_EXPIN_W-1], s1_q.exp} + {{(C_EINT_W-1){1'b0}}, hi};

  fpu_round u_round (
    .m     (m_n),
    .g     (g),
    .s     (s),
    .sign  (s1_q.sign),
    .rm    (s1_q.rm),
    .m_rnd (m_rnd),
    .carry (carry)
  );

  assign e_fin         = e_norm + {{(C_EINT_W-1){1'b0}}, carry};
  assign unused_hidden = m_rnd[C_MANT];
  assign ovf           = $signed(e_fin) >= $signed(C_EINT_W'(C_EXP_MAX));
  assign unf           = $signed(e_fin) <= $signed({C_EINT_W{1'b0}});
  assign to_inf        = (s1_q.rm == C_RM_NEAREST)
                       | ((s1_q.rm == C_RM_PLUSINF)  & ~s1_q.sign)
                       | ((s1_q.rm == C_RM_MINUSINF) &  s1_q.sign);

  always_comb begin
    res_next = {s1_q.sign, e_fin[C_EXP-1:0], m_rnd[C_MANT-1:0]};
    if (s1_q.nan)       res_next = F_QNAN;
    else if (s1_q.zero) res_next = {s1_q.sign, 31'b0};
    else if (s1_q.inf)  res_next = {s1_q.sign, F_INF_MAG};
    else if (ovf)       res_next = {s1_q.sign, to_inf ? F_INF_MAG : F_MAXF_MAG};
    else if (unf)       res_next = {s1_q.sign, 31'b0};
  end

  // ---- pipeline control ----
  always_comb begin
    s1_v_d = s1_v_q;
    s1_d   = s1_q;
    if (accept) begin
      s1_v_d    = 1'b1;
      s1_d.rm   = RM_DI;
      s1_d.sign = Sign_prenorm_DI;
      s1_d.exp  = Exp_prenorm_DI;
      s1_d.prod = Mant_prod_DI;
      s1_d.zero = Zero_SI;
      s1_d.inf  = Inf_SI;
      s1_d.nan  = NaN_SI;
    end else if (s1_v_q & s2_ready) begin
      s1_v_d = 1'b0;
    end
  end

  always_comb begin
    s2_v_d = s2_v_q;
    res_d  = res_q;
    if (s2_ready) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) res_d = res_next;
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      s1_v_q <= 1'b0;
      s1_q   <= '0;
      s2_v_q <= 1'b0;
      res_q  <= '0;
    end else begin
      s1_v_q <= s1_v_d;
      s1_q   <= s1_d;
      s2_v_q <= s2_v_d;
      res_q  <= res_d;
    end
  end

  assign Out_valid_SO = s2_v_q;
  assign Result_DO    = res_q;

`ifdef FPU_MULT_NORM_FLAGS_EN
  logic       finite, of_f, uf_f, nx_f;
  logic [2:0] flags_q, flags_d;

  assign finite = ~s1_q.nan & ~s1_q.zero & ~s1_q.inf;
  assign of_f   = finite & ovf;
  assign uf_f   = finite & ~ovf & unf & (|s1_q.prod);
  assign nx_f   = finite & (g | s | of_f | uf_f);

  always_comb begin
    flags_d = flags_q;
    if (s2_ready & s1_v_q) flags_d = {of_f, uf_f, nx_f};
  end

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) flags_q <= '0;
    else        flags_q <= flags_d;
  end

  assign Flags_DO = flags_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fpu_mult_norm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fpu_mult_norm : randomized + directed bench with a scoreboard fed by an
//                    arithmetic reference model.          Revision: 1.0
// ---------------------------------------------------------------------------
module tb_fpu_mult_norm;
  import fpu_mult_norm_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  rm;
  logic        sign, zero, inf, nan;
  logic [9:0]  exp_in;
  logic [47:0] prod;
  logic [31:0] result;
  logic [2:0]  flags_o;

  always #5 clk = ~clk;

  fpu_mult_norm dut (
    .Clk_CI          (clk),
    .Rst_RI          (rst),
    .In_valid_SI     (in_valid),
    .In_ready_SO     (in_ready),
    .RM_DI           (rm),
    .Sign_prenorm_DI (sign),
    .Exp_prenorm_DI  (exp_in),
    .Mant_prod_DI    (prod),
    .Zero_SI         (zero),
    .Inf_SI          (inf),
    .NaN_SI          (nan),
    .Out_valid_SO    (out_valid),
    .Out_ready_SI    (out_ready),
    .Result_DO       (result)
`ifdef FPU_MULT_NORM_FLAGS_EN
    ,
    .Flags_DO        (flags_o)
`endif
  );

`ifndef FPU_MULT_NORM_FLAGS_EN
  assign flags_o = 3'b000;
`endif

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          acc_cyc, pop_cyc;
  logic [34:0] sb_q[$];
  logic [31:0] last_out;
  logic        stall_prev = 1'b0;
  logic [31:0] prev_res;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference: returns {OF,UF,NX,result}.
  function automatic logic [34:0] model(input s1_beat_t b);
    longint unsigned p, m, rem, half;
    int   sh, e;
    logic inexact, up, of, uf;
    logic [31:0] r;
    if (b.nan)  return {3'b000, 32'h7FC00000};
    if (b.zero) return {3'b000, b.sign, 31'b0};
    if (b.inf)  return {3'b000, b.sign, 8'hFF, 23'b0};
    p    = 64'(b.prod);
    sh   = (p >= (64'd1 << 47)) ? 24 : 23;
    e    = int'($signed(b.exp)) + (sh - 23);
    m    = p >> sh;
    rem  = p - (m << sh);
    half = 64'd1 << (sh - 1);
    inexact = (rem != 0);
    case (b.rm)
      2'd0:    up = (rem > half) || (rem == half && (m % 2) == 1);
      2'd2:    up = !b.sign && inexact;
      2'd3:    up = b.sign && inexact;
      default: up = 1'b0;
    endcase
    m = m + 64'(up);
    if (m == (64'd1 << 24)) begin
      m = 64'd1 << 23;
      e = e + 1;
    end
    of = 1'b0;
    uf = 1'b0;
    if (e >= 255) begin
      of = 1'b1;
      if (b.rm == 2'd0 || (b.rm == 2'd2 && !b.sign) || (b.rm == 2'd3 && b.sign))
        r = {b.sign, 8'hFF, 23'b0};
      else
        r = {b.sign, 8'hFE, 23'h7FFFFF};
    end else if (e <= 0) begin
      uf = (p != 0);
      r  = {b.sign, 31'b0};
    end else begin
      r = {b.sign, 8'(e), 23'(m)};
    end
    return {of, uf, inexact | of | uf, r};
  endfunction

  function automatic s1_beat_t mk(input logic [1:0] r, input logic sg, input int e, input logic [47:0] p);
    s1_beat_t b;
    b      = '0;
    b.rm   = r;
    b.sign = sg;
    b.exp  = 10'(e);
    b.prod = p;
    return b;
  endfunction

  function automatic s1_beat_t rand_beat();
    s1_beat_t    b;
    logic [63:0] rr;
    b    = '0;
    rr   = {$urandom, $urandom};
    b.rm = 2'($urandom_range(0, 3));
    b.sign = 1'($urandom);
    case ($urandom_range(0, 9))
      0:       b.exp = 10'($urandom);
      1:       b.exp = 10'($urandom_range(250, 260));
      2:       b.exp = 10'(int'($urandom_range(0, 6)) - 3);
      default: b.exp = 10'($urandom_range(60, 200));
    endcase
    b.prod = rr[47:0];
    if ($urandom_range(0, 7) != 0 && b.prod[47:46] == 2'b00) b.prod[46] = 1'b1;
    if ($urandom_range(0, 5) == 0) b.prod[22:0] = 23'h400000;
    b.nan  = ($urandom_range(0, 19) == 0);
    b.zero = ($urandom_range(0, 19) == 0);
    b.inf  = ($urandom_range(0, 19) == 0);
    return b;
  endfunction

  // One clock: drive, then check outputs and record an accept before the edge.
  task automatic cycle(input logic vld, input s1_beat_t b, input logic ordy, output logic acc);
    logic [34:0] exp_v;
    @(negedge clk);
    in_valid  = vld;
    rm        = b.rm;
    sign      = b.sign;
    exp_in    = b.exp;
    prod      = b.prod;
    zero      = b.zero;
    inf       = b.inf;
    nan       = b.nan;
    out_ready = ordy;
    #1;
    if (stall_prev) begin
      check_eq("hold_valid", {31'b0, out_valid}, 32'd1);
      check_eq("hold_res", result, prev_res);
    end
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_empty", 32'(sb_q.size()), 32'd1);
      end else begin
        exp_v = sb_q.pop_front();
        check_eq("res", result, exp_v[31:0]);
`ifdef FPU_MULT_NORM_FLAGS_EN
        check_eq("flags", {29'b0, flags_o}, {29'b0, exp_v[34:32]});
`endif
        last_out = result;
        pop_cyc  = cyc;
      end
    end
    stall_prev = out_valid & ~out_ready;
    prev_res   = result;
    acc = vld & in_ready;
    if (acc) begin
      sb_q.push_back(model(b));
      acc_cyc = cyc;
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    check_eq("rst_ready", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    check_eq("rst_valid", {31'b0, out_valid}, 32'd0);
    check_eq("rst_res", result, 32'd0);
    rst = 1'b0;
    sb_q.delete();
    stall_prev = 1'b0;
  endtask

  task automatic run_dir(input string tag, input s1_beat_t b, input logic [31:0] exp_res);
    logic acc;
    logic got;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      cycle(1'b1, b, 1'b1, acc);
      got = acc;
    end
    check_eq({tag, "_acc"}, {31'b0, got}, 32'd1);
    for (int k = 0; k < 20 && sb_q.size() > 0; k++) cycle(1'b0, b, 1'b1, acc);
    check_eq({tag, "_drain"}, 32'(sb_q.size()), 32'd0);
    check_eq(tag, last_out, exp_res);
  endtask

  initial begin
    s1_beat_t b;
    logic     acc;
    int       taken;
    s1_beat_t bp[4];

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    rm = 2'd0; sign = 1'b0; exp_in = '0; prod = '0;
    zero = 1'b0; inf = 1'b0; nan = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();

    run_dir("one", mk(2'd0, 1'b0, 127, 48'h400000000000), 32'h3F800000);
    check_eq("latency", 32'(pop_cyc - acc_cyc), 32'd2);
    run_dir("one_5sq", mk(2'd0, 1'b0, 127, 48'h900000000000), 32'h40100000);
    run_dir("rne_tie", mk(2'd0, 1'b0, 127, 48'h400000400000), 32'h3F800000);
    run_dir("pinf_tie", mk(2'd2, 1'b0, 127, 48'h400000400000), 32'h3F800001);
    run_dir("rnd_carry", mk(2'd0, 1'b0, 127, 48'h7FFFFFC00000), 32'h40000000);
    run_dir("rnd_ovf", mk(2'd0, 1'b0, 254, 48'h7FFFFFC00000), 32'h7F800000);
    run_dir("e254", mk(2'd0, 1'b0, 254, 48'h400000000000), 32'h7F000000);
    run_dir("ovf_rne", mk(2'd0, 1'b0, 300, 48'h400000000000), 32'h7F800000);
    run_dir("ovf_trunc", mk(2'd1, 1'b0, 300, 48'h400000000000), 32'h7F7FFFFF);
    run_dir("ovf_minf", mk(2'd3, 1'b0, 300, 48'h400000000000), 32'h7F7FFFFF);
    run_dir("ovf_pinf_neg", mk(2'd2, 1'b1, 300, 48'h400000000000), 32'hFF7FFFFF);
    run_dir("ovf_max_exp", mk(2'd0, 1'b0, 511, 48'hC00000000000), 32'h7F800000);
    run_dir("e1", mk(2'd0, 1'b0, 1, 48'h400000000000), 32'h00800000);
    run_dir("e0_flush", mk(2'd0, 1'b0, 0, 48'h400000000000), 32'h00000000);
    run_dir("unf_neg", mk(2'd0, 1'b1, -5, 48'h400000000000), 32'h80000000);
    run_dir("unf_min_exp", mk(2'd0, 1'b0, -512, 48'hC00000000000), 32'h00000000);
    b = mk(2'd2, 1'b1, 300, 48'h123456789ABC); b.nan = 1'b1; b.zero = 1'b1;
    run_dir("nan", b, 32'h7FC00000);
    b = mk(2'd0, 1'b1, 300, 48'h400000000000); b.zero = 1'b1; b.inf = 1'b1;
    run_dir("zero", b, 32'h80000000);
    b = mk(2'd0, 1'b1, -5, 48'h400000000000); b.inf = 1'b1;
    run_dir("inf", b, 32'hFF800000);

    // Backpressure: consumer stalls 3 cycles while 4 beats are offered.
    for (int i = 0; i < 4; i++) bp[i] = rand_beat();
    taken = 0;
    for (int c = 0; c < 3; c++) begin
      cycle(1'b1, bp[taken], 1'b0, acc);
      if (acc) taken++;
    end
    check_eq("bp_cap", 32'(taken), 32'd2);
    check_eq("bp_ready", {31'b0, in_ready}, 32'd0);
    for (int c = 0; c < 30 && (taken < 4 || sb_q.size() > 0); c++) begin
      cycle(taken < 4, bp[taken % 4], 1'b1, acc);
      if (acc) taken++;
    end
    check_eq("bp_drain", 32'(sb_q.size()), 32'd0);

    // Random traffic with random backpressure.
    b = rand_beat();
    for (int c = 0; c < 600; c++) begin
      cycle($urandom_range(0, 9) < 7, b, $urandom_range(0, 9) < 7, acc);
      if (acc) b = rand_beat();
    end
    for (int c = 0; c < 40 && sb_q.size() > 0; c++) cycle(1'b0, b, 1'b1, acc);
    check_eq("rand_drain", 32'(sb_q.size()), 32'd0);

    // Reset with two beats in flight: nothing may emerge afterwards.
    for (int c = 0; c < 3; c++) cycle(1'b1, rand_beat(), 1'b0, acc);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    check_eq("rst_mid_valid", {31'b0, out_valid}, 32'd0);
    rst = 1'b0;
    sb_q.delete();
    stall_prev = 1'b0;
    for (int c = 0; c < 4; c++) begin
      cycle(1'b0, b, 1'b1, acc);
      check_eq("rst_mid_quiet", {31'b0, out_valid}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
